// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Galois LFSR link (generator and lock checker).
package lfsr_pkg;

    // Word width the tap set is defined for.
    localparam int unsigned LFSR_W = 8;

    // Default reset/fallback seed; an all-zero state would lock the LFSR.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;

    // Feedback comes from the MSB; it also feeds bit 0 through the shift.
    localparam int unsigned FB_BIT = 7;

    // Bits that get the feedback XORed in on top of the shift: positions 2, 5 and 6.
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0110_0100;

    // Link FSM encodings, shared so both ends decode the same values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } lfsr_state_e;

    // One Galois step: shift left, feedback into bit 0 and into each tap.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[FB_BIT];
        return {s[LFSR_W-2:0], fb} ^ (fb ? TAP_MASK : '0);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state function of the link LFSR, n = step(s).
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_next
);

    // Pure function of the current state; no storage here.
    always_comb begin
        o_next = lfsr_next(i_state);
    end

endmodule

// File: rtl/lfsr_generator.sv
// Transmit-side PRBS source: seedable 8-bit Galois LFSR with a programmable
// burst of corrupted output words for exercising the receiver's lock logic.
module lfsr_generator
    import lfsr_pkg::*;
#(
    parameter int unsigned             LFSR_WIDTH    = LFSR_W,
    parameter logic [LFSR_WIDTH-1:0]   SEED          = LFSR_SEED,
    parameter int unsigned             ERR_LEN_WIDTH = 3,
    parameter logic [LFSR_WIDTH-1:0]   ERR_MASK      = 8'h01
) (
    input  logic                     clk,
    input  logic                     i_reset_n,
    input  logic                     i_enable,
    input  logic                     i_seed_load,
    input  logic [LFSR_WIDTH-1:0]    i_seed,
    input  logic                     i_err_req,
    input  logic [ERR_LEN_WIDTH-1:0] i_err_len,
    output logic [LFSR_WIDTH-1:0]    o_LFSR,
    output logic                     o_valid,
    output logic                     o_err_active,
    output logic                     o_wrap
);

    // Only LFSR_WIDTH == 8 is supported; the step function is fixed to the 8-bit tap set.

    logic [LFSR_WIDTH-1:0]    state_q, state_d;
    logic [LFSR_WIDTH-1:0]    seed_q, seed_d;
    logic [LFSR_WIDTH-1:0]    lfsr_q, lfsr_d;
    logic                     valid_q, valid_d;
    logic                     err_active_q, err_active_d;
    logic                     wrap_q, wrap_d;
    logic [ERR_LEN_WIDTH-1:0] err_cnt_q, err_cnt_d;
    lfsr_state_e              fsm_q, fsm_d;

    logic [LFSR_WIDTH-1:0]    step_next;
    logic [LFSR_WIDTH-1:0]    load_value;
    logic                     emit;
    logic                     corrupt;

    lfsr_step u_step (
        .i_state (state_q),
        .o_next  (step_next)
    );

    // Decode this cycle's action; a zero seed falls back to SEED to avoid lock-up.
    always_comb begin
        emit       = i_enable & ~i_seed_load;
        corrupt    = (fsm_q == ST_ERR);
        load_value = (i_seed == '0) ? SEED : i_seed;
    end

    // Next-state for datapath, output registers and the burst FSM.
    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        lfsr_d       = lfsr_q;
        err_active_d = err_active_q;
        err_cnt_d    = err_cnt_q;
        fsm_d        = fsm_q;
        valid_d      = emit;
        // The emitted word is the last of the orbit when its successor is the seed.
        wrap_d       = emit && (step_next == seed_q);

        if (i_seed_load) begin
            // Seed load wins over enable and aborts any burst in progress.
            state_d   = load_value;
            seed_d    = load_value;
            err_cnt_d = '0;
            fsm_d     = ST_IDLE;
        end else begin
            if (emit) begin
                // Mask touches the output only, so the sequence resumes cleanly after a burst.
                lfsr_d       = state_q ^ (corrupt ? ERR_MASK : '0);
                err_active_d = corrupt;
                state_d      = step_next;
            end

            unique case (fsm_q)
                ST_IDLE: begin
                    if (emit) begin
                        fsm_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Corruption begins with the next emitted word, not this one.
                    if (i_err_req && (i_err_len != '0)) begin
                        err_cnt_d = i_err_len;
                        fsm_d     = ST_ERR;
                    end
                end
                ST_ERR: begin
                    // Count emitted words only; stalls leave the count alone.
                    if (emit) begin
                        if (err_cnt_q <= ERR_LEN_WIDTH'(1)) begin
                            err_cnt_d = '0;
                            fsm_d     = ST_RUN;
                        end else begin
                            err_cnt_d = err_cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    err_cnt_d = '0;
                    fsm_d     = ST_IDLE;
                end
            endcase
        end
    end

    // All state and outputs registered; asynchronous active-low reset.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= SEED;
            seed_q       <= SEED;
            lfsr_q       <= '0;
            valid_q      <= 1'b0;
            err_active_q <= 1'b0;
            wrap_q       <= 1'b0;
            err_cnt_q    <= '0;
            fsm_q        <= ST_IDLE;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            lfsr_q       <= lfsr_d;
            valid_q      <= valid_d;
            err_active_q <= err_active_d;
            wrap_q       <= wrap_d;
            err_cnt_q    <= err_cnt_d;
            fsm_q        <= fsm_d;
        end
    end

    // Drive ports straight from the output flops.
    always_comb begin
        o_LFSR       = lfsr_q;
        o_valid      = valid_q;
        o_err_active = err_active_q;
        o_wrap       = wrap_q;
    end

endmodule

// File: tb/tb_lfsr_generator.sv
// Directed self-checking bench for lfsr_generator.
module tb_lfsr_generator;

    logic       clk;
    logic       i_reset_n;
    logic       i_enable;
    logic       i_seed_load;
    logic [7:0] i_seed;
    logic       i_err_req;
    logic [2:0] i_err_len;
    logic [7:0] o_LFSR;
    logic       o_valid;
    logic       o_err_active;
    logic       o_wrap;

    int tests;
    int fails;

    lfsr_generator dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_enable     (i_enable),
        .i_seed_load  (i_seed_load),
        .i_seed       (i_seed),
        .i_err_req    (i_err_req),
        .i_err_len    (i_err_len),
        .o_LFSR       (o_LFSR),
        .o_valid      (o_valid),
        .o_err_active (o_err_active),
        .o_wrap       (o_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference step written bit by bit from the tap equations.
    function automatic logic [7:0] model_next(input logic [7:0] s);
        logic [7:0] n;
        logic       fb;
        fb   = s[7];
        n[0] = fb;
        n[1] = s[0];
        n[2] = s[1] ^ fb;
        n[3] = s[2];
        n[4] = s[3];
        n[5] = s[4] ^ fb;
        n[6] = s[5] ^ fb;
        n[7] = s[6];
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq [10];
        logic [7:0] cur;
        logic [7:0] s;
        int         period;
        int         wraps;
        int         wrap_at;

        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08; seq[4] = 8'h10;
        seq[5] = 8'h20; seq[6] = 8'h40; seq[7] = 8'h80; seq[8] = 8'h65; seq[9] = 8'hCA;

        tests = 0;
        fails = 0;

        // Reset state
        i_reset_n   = 1'b0;
        i_enable    = 1'b0;
        i_seed_load = 1'b0;
        i_seed      = 8'h00;
        i_err_req   = 1'b0;
        i_err_len   = 3'd0;
        #2;
        check("rst_lfsr", o_LFSR, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_err", o_err_active, 1'b0);
        check("rst_wrap", o_wrap, 1'b0);
        @(negedge clk);
        i_reset_n = 1'b1;

        // Seed load 01, then ten emits of the known sequence
        i_seed_load = 1'b1;
        i_seed      = 8'h01;
        tick();
        check("load_valid", o_valid, 1'b0);
        i_seed_load = 1'b0;
        i_enable    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("seq%0d", k), o_LFSR, seq[k]);
            check($sformatf("seq%0d_valid", k), o_valid, 1'b1);
            check($sformatf("seq%0d_err", k), o_err_active, 1'b0);
        end
        cur = model_next(8'hCA);

        // Burst of 3: request word is clean, next 3 masked, 4th clean
        i_err_req = 1'b1;
        i_err_len = 3'd3;
        tick();
        check("burst3_req_word", o_LFSR, cur);
        check("burst3_req_err", o_err_active, 1'b0);
        cur = model_next(cur);
        i_err_req = 1'b0;
        i_err_len = 3'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("burst3_w%0d", k), o_LFSR, cur ^ 8'h01);
            check($sformatf("burst3_e%0d", k), o_err_active, 1'b1);
            cur = model_next(cur);
        end
        tick();
        check("burst3_after", o_LFSR, cur);
        check("burst3_after_err", o_err_active, 1'b0);
        cur = model_next(cur);

        // Burst of 2 with a stall in the middle
        i_err_req = 1'b1;
        i_err_len = 3'd2;
        tick();
        check("burst2_req_word", o_LFSR, cur);
        cur = model_next(cur);
        i_err_req = 1'b0;
        i_err_len = 3'd0;
        tick();
        check("burst2_w0", o_LFSR, cur ^ 8'h01);
        check("burst2_e0", o_err_active, 1'b1);
        i_enable = 1'b0;
        tick();
        check("stall_valid", o_valid, 1'b0);
        check("stall_hold", o_LFSR, cur ^ 8'h01);
        cur = model_next(cur);
        i_enable = 1'b1;
        tick();
        check("burst2_w1", o_LFSR, cur ^ 8'h01);
        check("burst2_e1", o_err_active, 1'b1);
        cur = model_next(cur);
        tick();
        check("burst2_after", o_LFSR, cur);
        check("burst2_after_err", o_err_active, 1'b0);

        // Zero seed with enable: no emit, then falls back to 01
        i_seed_load = 1'b1;
        i_seed      = 8'h00;
        tick();
        check("zload_valid", o_valid, 1'b0);
        check("zload_wrap", o_wrap, 1'b0);
        i_seed_load = 1'b0;
        // Error request in IDLE must be ignored
        i_enable  = 1'b0;
        i_err_req = 1'b1;
        i_err_len = 3'd3;
        tick();
        i_err_req = 1'b0;
        i_err_len = 3'd0;
        i_enable  = 1'b1;
        tick();
        check("zseed_word", o_LFSR, 8'h01);
        check("idle_req_ignored", o_err_active, 1'b0);
        // Zero length in RUN must be ignored
        i_err_req = 1'b1;
        i_err_len = 3'd0;
        tick();
        i_err_req = 1'b0;
        tick();
        check("len0_word", o_LFSR, 8'h04);
        check("len0_err", o_err_active, 1'b0);

        // One full orbit from seed 01: exactly one wrap, on the last word
        s      = model_next(8'h01);
        period = 1;
        while (s != 8'h01 && period < 300) begin
            s = model_next(s);
            period++;
        end
        i_seed_load = 1'b1;
        i_seed      = 8'h01;
        tick();
        i_seed_load = 1'b0;
        wraps   = 0;
        wrap_at = -1;
        for (int k = 0; k < period + 3; k++) begin
            tick();
            if (o_wrap) begin
                wraps++;
                wrap_at = k;
            end
        end
        check("wrap_count", wraps, 1);
        check("wrap_index", wrap_at, period - 1);

        // Asynchronous reset mid-burst
        i_seed_load = 1'b1;
        i_seed      = 8'h01;
        tick();
        i_seed_load = 1'b0;
        tick();
        i_err_req = 1'b1;
        i_err_len = 3'd3;
        tick();
        i_err_req = 1'b0;
        i_err_len = 3'd0;
        tick();
        check("pre_rst_err", o_err_active, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_lfsr", o_LFSR, 8'h00);
        check("arst_valid", o_valid, 1'b0);
        check("arst_err", o_err_active, 1'b0);
        check("arst_wrap", o_wrap, 1'b0);
        i_enable = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b1;
        i_enable  = 1'b1;
        tick();
        check("post_rst_word", o_LFSR, 8'h01);
        check("post_rst_valid", o_valid, 1'b1);
        check("post_rst_err", o_err_active, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_generator.md
Name: lfsr_generator

Overview:
- Transmit-side PRBS source for the 8-bit Galois LFSR link. Produces the word stream that the downstream LFSR lock checker tracks.
- Supports seed load, per-cycle advance enable, and a programmable burst of corrupted output words. The burst lets the receiver's lock/unlock thresholds be exercised in system.
- Sits at the stimulus end of the link, with its output registered.

Parameters:
- LFSR_WIDTH, 8, word width; the tap set is defined for 8 only, and other values are unsupported.
- SEED, 8'h01, reset and fallback seed; must be non-zero.
- ERR_LEN_WIDTH, 3, width of the error-burst length request.
- ERR_MASK, 8'h01, XOR mask applied to an output word while corruption is active.

Ports:
- clk  in  1  single clock, rising edge
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_enable  in  1  advance the LFSR one step and emit one word this cycle
- i_seed_load  in  1  load i_seed into the LFSR state this cycle
- i_seed  in  LFSR_WIDTH  seed value
- i_err_req  in  1  single-cycle request to start an error burst
- i_err_len  in  ERR_LEN_WIDTH  number of corrupted words in the burst; 0 means the request is ignored
- o_LFSR  out  LFSR_WIDTH  registered output word
- o_valid  out  1  o_LFSR holds a new word this cycle
- o_err_active  out  1  the current o_LFSR word is corrupted
- o_wrap  out  1  one-cycle pulse: the state has returned to the loaded seed

Behaviour:
- Reset, asynchronous while i_reset_n=0:
  - state=SEED, seed_reg=SEED, o_LFSR=0, o_valid=0, o_err_active=0, o_wrap=0.
  - err_cnt=0; FSM goes to ST_IDLE.
- Step function, with s the current state and fb=s[7]:
  - n[0]=fb, n[1]=s[0], n[2]=s[1]^fb, n[3]=s[2]
  - n[4]=s[3], n[5]=s[4]^fb, n[6]=s[5]^fb, n[7]=s[6]
- Emit: in a cycle with i_enable=1 and i_seed_load=0:
  - o_LFSR <= s ^ (corrupt ? ERR_MASK : 0); o_valid <= 1; state <= n(s).
  - Latency is 1 cycle, so the first word after a seed load equals the seed.
  - The error mask affects the output only and never the state. The stream therefore resumes its correct sequence right after the burst.
- i_enable=0: state holds, o_valid <= 0, and o_LFSR holds its last value.
- Seed load:
  - i_seed_load=1 loads seed_reg and state with i_seed, or with SEED if i_seed==0 (zero-lock guard).
  - Seed load has priority over i_enable in the same cycle: o_valid <= 0 and no word is emitted.
  - A seed load aborts any burst: err_cnt <= 0 and the FSM goes to ST_IDLE.
- o_wrap <= 1 for one cycle when an emit occurs and n(s)==seed_reg.
- FSM:
  - ST_IDLE: o_valid low. Go to ST_RUN on the first i_enable=1 with i_seed_load=0; that cycle emits.
  - ST_RUN: normal emission. If i_err_req=1 and i_err_len!=0, set err_cnt <= i_err_len and go to ST_ERR. Corruption starts with the next emitted word, not the current one.
  - ST_ERR: corrupt=1 on each emit, and err_cnt decrements per emitted word only; stalled cycles do not count. When a word is emitted with err_cnt==1, go back to ST_RUN.
  - o_err_active is registered alongside o_LFSR, so it marks exactly the corrupted words.
- Boundaries:
  - i_err_req while in ST_ERR or ST_IDLE is ignored.
  - i_err_len=0 is ignored.
  - A reset mid-burst clears all state.
  - err_cnt must never underflow.

Decomposition:
- Shared package (lfsr_pkg), used by both generator and checker:
  - LFSR_WIDTH and the default SEED.
  - The tap positions {2,5,6} and the feedback-from-bit-7 rule.
  - The FSM state encodings ST_IDLE/ST_RUN/ST_ERR, 2 bits.
- One sub-module, lfsr_step: purely combinational next-state function, n = step(s). The checker reuses it for its expected-value path.

Test Plan:
- Reset, load seed 8'h01, hold i_enable=1 → o_LFSR = 01,02,04,08,10,20,40,80,65,CA; o_valid high from the first emit; o_err_active=0.
- i_seed_load=1 with i_seed=8'h00 → first emitted word is 8'h01 (SEED fallback); i_seed_load and i_enable asserted together → o_valid=0 in that cycle.
- In ST_RUN, pulse i_err_req with i_err_len=3 → the next 3 words equal the expected sequence XOR 8'h01, with o_err_active=1; the 4th word is the correct sequence value with o_err_active=0.
- Burst of len 2 with i_enable toggling 1,0,1 → only the emitted words are corrupted; the stalled cycle shows o_valid=0 and err_cnt is unchanged.
- Run from seed until o_wrap → o_wrap pulses exactly once per full orbit; the checker connected downstream asserts o_lock after 5 consecutive good words.
- Assert i_reset_n=0 asynchronously mid-burst → all outputs are 0 immediately; after release, the first enabled word is 8'h01.
